// File: rtl/sargantana_icache_flush_unit_if.sv
// Flush-unit signal bundle: requests from the core/cache side,
// valid-bit write port and status back from the flush unit.
interface sargantana_icache_flush_unit_if #(
    parameter int ICACHE_N_WAY     = 4,
    parameter int ICACHE_IDX_WIDTH = 6
);
    logic                        flush_req_i;
    logic                        inval_req_i;
    logic [ICACHE_IDX_WIDTH-1:0] inval_idx_i;
    logic                        cache_busy_i;
    logic                        flush_ena_o;
    logic                        valid_we_o;
    logic [ICACHE_IDX_WIDTH-1:0] valid_addr_o;
    logic [ICACHE_N_WAY-1:0]     valid_way_mask_o;
    logic                        inval_ack_o;
    logic                        flush_done_o;
    logic                        flush_busy_o;

    modport master (
        output flush_req_i, inval_req_i, inval_idx_i, cache_busy_i,
        input  flush_ena_o, valid_we_o, valid_addr_o, valid_way_mask_o,
        input  inval_ack_o, flush_done_o, flush_busy_o
    );

    modport slave (
        input  flush_req_i, inval_req_i, inval_idx_i, cache_busy_i,
        output flush_ena_o, valid_we_o, valid_addr_o, valid_way_mask_o,
        output inval_ack_o, flush_done_o, flush_busy_o
    );
endinterface

// File: rtl/sargantana_icache_flush_unit.sv
// I-cache valid-bit clear sequencer: full sweep (fence.i) or
// single-set invalidation, one set per cycle, flush has precedence.
module sargantana_icache_flush_unit #(
    parameter int ICACHE_N_WAY     = 4,
    parameter int ICACHE_IDX_WIDTH = 6
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    sargantana_icache_flush_unit_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FLUSH,
        DONE,
        INVAL
    } state_t;

    state_t                      state_q, state_d;
    logic [ICACHE_IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic [ICACHE_IDX_WIDTH-1:0] inv_idx_q, inv_idx_d;
    logic                        pend_q, pend_d;
    logic                        flush_any;

    assign flush_any = bus.flush_req_i | pend_q;

    // State, sweep counter, pending flag and latched index
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            inv_idx_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inv_idx_q <= inv_idx_d;
            pend_q    <= pend_d;
        end
    end

    // Next-state: a flush request is remembered in any state and
    // only consumed when a sweep actually starts
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inv_idx_d = inv_idx_q;
        pend_d    = pend_q | bus.flush_req_i;
        unique case (state_q)
            IDLE: begin
                if (flush_any && !bus.cache_busy_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (flush_any) begin
                    state_d = WAIT;
                end else if (bus.inval_req_i && !bus.cache_busy_i) begin
                    state_d   = INVAL;
                    inv_idx_d = bus.inval_idx_i;
                end
            end
            WAIT: begin
                if (!bus.cache_busy_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            INVAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.flush_ena_o      = (state_q == FLUSH);
        bus.valid_we_o       = (state_q == FLUSH) || (state_q == INVAL);
        bus.inval_ack_o      = (state_q == INVAL);
        bus.flush_done_o     = (state_q == DONE);
        bus.flush_busy_o     = pend_q || (state_q == WAIT) ||
                               (state_q == FLUSH) || (state_q == DONE);
        bus.valid_way_mask_o = {ICACHE_N_WAY{bus.valid_we_o}};
        bus.valid_addr_o     = '0;
        if (state_q == FLUSH) begin
            bus.valid_addr_o = cnt_q;
        end else if (state_q == INVAL) begin
            bus.valid_addr_o = inv_idx_q;
        end
    end
endmodule

// File: tb/tb_sargantana_icache_flush_unit.sv
// Bench for the i-cache flush unit: expected valid-bit writes are
// queued at stimulus time and popped by a negedge monitor.
module tb_sargantana_icache_flush_unit;
    localparam int NW   = 4;
    localparam int IDX  = 6;
    localparam int SETS = 1 << IDX;

    typedef struct {
        logic [IDX-1:0] addr;
        logic           fl;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [IDX+NW+1:0] got, req;
    int compared = 0;
    int mismatched = 0;
    int dones = 0;

    always #5 clk = ~clk;

    sargantana_icache_flush_unit_if #(
        .ICACHE_N_WAY(NW),
        .ICACHE_IDX_WIDTH(IDX)
    ) bus ();

    sargantana_icache_flush_unit #(
        .ICACHE_N_WAY(NW),
        .ICACHE_IDX_WIDTH(IDX)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .bus(bus)
    );

    // Scoreboard monitor: every write must match the queue head
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.flush_done_o) dones++;
            compared++;
            if (bus.valid_we_o) begin
                got = {bus.valid_addr_o, bus.valid_way_mask_o,
                       bus.flush_ena_o, bus.inval_ack_o};
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL write_unexpected got=%h required=none", got);
                end else begin
                    mon_e = exp_q.pop_front();
                    req = {mon_e.addr, 4'hF, mon_e.fl, ~mon_e.fl};
                    if (got !== req) begin
                        mismatched++;
                        $display("FAIL write got=%h required=%h", got, req);
                    end
                end
            end else if ({bus.valid_way_mask_o, bus.valid_addr_o,
                          bus.flush_ena_o, bus.inval_ack_o} !== '0) begin
                mismatched++;
                $display("FAIL idle_outputs mask=%h addr=%0d ena=%b ack=%b required=0",
                         bus.valid_way_mask_o, bus.valid_addr_o,
                         bus.flush_ena_o, bus.inval_ack_o);
            end
        end
    end

    task automatic push_flush(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_t'{addr: IDX'(i), fl: 1'b1});
    endtask

    task automatic pulse_flush();
        bus.flush_req_i = 1'b1;
        @(posedge clk) #1;
        bus.flush_req_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n++;
            if (bus.flush_done_o) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        bus.flush_req_i  = 1'b0;
        bus.inval_req_i  = 1'b0;
        bus.inval_idx_i  = '0;
        bus.cache_busy_i = 1'b0;
        rstn = 1'b0;
        #3;
        compared++;
        if ({bus.flush_ena_o, bus.valid_we_o, bus.valid_addr_o, bus.valid_way_mask_o,
             bus.inval_ack_o, bus.flush_done_o, bus.flush_busy_o} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs got nonzero required=0");
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flush();
        int n, busy_bad;
        @(negedge clk);
        push_flush(SETS);
        pulse_flush();
        n = 0;
        busy_bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n++;
            if (!bus.flush_busy_o) busy_bad++;
            if (bus.flush_done_o) break;
        end
        compared++;
        if (n !== 65) begin
            mismatched++;
            $display("FAIL flush_done_latency got=%0d required=65", n);
        end
        compared++;
        if (busy_bad !== 0) begin
            mismatched++;
            $display("FAIL flush_busy_low got=%0d required=0", busy_bad);
        end
        @(negedge clk);
        compared++;
        if ({bus.flush_done_o, bus.flush_busy_o} !== 2'b00) begin
            mismatched++;
            $display("FAIL flush_after_done done=%b busy=%b required=00",
                     bus.flush_done_o, bus.flush_busy_o);
        end
        #1;
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL flush_writes_left got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_wait();
        int n;
        @(negedge clk);
        bus.cache_busy_i = 1'b1;
        push_flush(SETS);
        pulse_flush();
        repeat (5) begin
            @(negedge clk);
            compared++;
            if ({bus.valid_we_o, bus.flush_busy_o, bus.flush_ena_o} !== 3'b010) begin
                mismatched++;
                $display("FAIL wait_state we/busy/ena=%b%b%b required=010",
                         bus.valid_we_o, bus.flush_busy_o, bus.flush_ena_o);
            end
        end
        bus.cache_busy_i = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n++;
            if (bus.valid_we_o) break;
        end
        compared++;
        if (n !== 1) begin
            mismatched++;
            $display("FAIL wait_first_write got=%0d required=1", n);
        end
        wait_done(n);
        compared++;
        if (n !== 64) begin
            mismatched++;
            $display("FAIL wait_done_latency got=%0d required=64", n);
        end
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL wait_writes_left got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_inval();
        int d0;
        @(negedge clk);
        d0 = dones;
        exp_q.push_back(exp_t'{addr: IDX'(37), fl: 1'b0});
        bus.inval_idx_i = IDX'(37);
        bus.inval_req_i = 1'b1;
        @(posedge clk) #1;
        compared++;
        if ({bus.inval_ack_o, bus.valid_we_o, bus.valid_addr_o, bus.flush_ena_o}
            !== {1'b1, 1'b1, IDX'(37), 1'b0}) begin
            mismatched++;
            $display("FAIL inval_write ack=%b we=%b addr=%0d required ack=1 we=1 addr=37",
                     bus.inval_ack_o, bus.valid_we_o, bus.valid_addr_o);
        end
        bus.inval_req_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() !== 0 || dones !== d0) begin
            mismatched++;
            $display("FAIL inval_leftover q=%0d dones=%0d required q=0 dones=%0d",
                     exp_q.size(), dones, d0);
        end
    endtask

    task automatic test_both();
        int n, d0;
        bit found;
        @(negedge clk);
        d0 = dones;
        push_flush(SETS);
        exp_q.push_back(exp_t'{addr: IDX'(12), fl: 1'b0});
        bus.inval_idx_i = IDX'(12);
        bus.inval_req_i = 1'b1;
        pulse_flush();
        found = 0;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n++;
            if (bus.inval_ack_o) begin
                found = 1;
                break;
            end
        end
        compared++;
        if (!found || n !== 67) begin
            mismatched++;
            $display("FAIL both_ack_cycle got=%0d found=%0d required=67", n, found);
        end
        compared++;
        if (dones - d0 !== 1) begin
            mismatched++;
            $display("FAIL both_done_count got=%0d required=1", dones - d0);
        end
        @(posedge clk) #1;
        bus.inval_req_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL both_writes_left got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        bit found;
        @(negedge clk);
        push_flush(SETS);
        pulse_flush();
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.valid_we_o && bus.valid_addr_o == IDX'(20)) begin
                found = 1;
                break;
            end
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL b2b_addr20 got=0 required=1");
        end
        push_flush(SETS);
        pulse_flush();
        wait_done(n1);
        wait_done(n2);
        compared++;
        if (n1 !== 44 || n2 !== 66) begin
            mismatched++;
            $display("FAIL b2b_done_gaps got=%0d,%0d required=44,66", n1, n2);
        end
        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() !== 0 || bus.flush_busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_end q=%0d busy=%b required q=0 busy=0",
                     exp_q.size(), bus.flush_busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int n, d0;
        bit found;
        @(negedge clk);
        push_flush(31);
        pulse_flush();
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.valid_we_o && bus.valid_addr_o == IDX'(30)) begin
                found = 1;
                break;
            end
        end
        #2;
        rstn = 1'b0;
        d0 = dones;
        #1;
        compared++;
        if (!found || {bus.flush_ena_o, bus.valid_we_o, bus.valid_addr_o,
             bus.valid_way_mask_o, bus.inval_ack_o, bus.flush_done_o,
             bus.flush_busy_o} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs found=%0d we=%b busy=%b required all 0",
                     found, bus.valid_we_o, bus.flush_busy_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (70) @(negedge clk);
        #1;
        compared++;
        if (dones !== d0 || exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL reset_mid_quiet dones=%0d q=%0d required dones=%0d q=0",
                     dones, exp_q.size(), d0);
        end
        @(negedge clk);
        push_flush(SETS);
        pulse_flush();
        wait_done(n);
        compared++;
        if (n !== 65) begin
            mismatched++;
            $display("FAIL reset_mid_reflush got=%0d required=65", n);
        end
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL reset_mid_left got=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_flush();
        test_wait();
        test_inval();
        test_both();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sargantana_icache_flush_unit.md
# sargantana_icache_flush_unit

Sequencer that clears instruction-cache valid bits for a full flush (fence.i) or a single-set invalidation, one set per cycle. Sits beside the replace/valid-bit stage. Its `flush_ena_o` gives flushes precedence over invalidations there. Its write-enable, address and way-mask outputs are muxed onto the valid-bit RAM port ahead of that stage.

## Interface
Parameters:
- ICACHE_N_WAY, 4, number of ways (power of two, ≥2)
- ICACHE_IDX_WIDTH, 6, set-index width; sweep length = 2^ICACHE_IDX_WIDTH

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock
- rstn_i  in  1  reset
- flush_req_i  in  1  flush request; one-cycle pulse, any cycle
- inval_req_i  in  1  single-set invalidation request; level, held until ack
- inval_idx_i  in  ICACHE_IDX_WIDTH  set to invalidate; valid while inval_req_i high
- cache_busy_i  in  1  refill/lookup in flight; no valid-bit write may start while high
- flush_ena_o  out  1  full sweep in progress
- valid_we_o  out  1  valid-bit write this cycle
- valid_addr_o  out  ICACHE_IDX_WIDTH  set being cleared
- valid_way_mask_o  out  ICACHE_N_WAY  ways written; all ones whenever valid_we_o=1, else 0
- inval_ack_o  out  1  one-cycle pulse, invalidation performed this cycle
- flush_done_o  out  1  one-cycle pulse, sweep complete
- flush_busy_o  out  1  flush pending or in progress; core must stall fetch

## Operation
- Registered state: FSM, a counter cnt[ICACHE_IDX_WIDTH-1:0], a pending flag pend, and a latched index inv_idx.
- FSM states:
  - IDLE: no write.
  - WAIT: flush pending, waiting for cache_busy_i=0.
  - FLUSH: sweep, one set per cycle.
  - DONE: done pulse.
  - INVAL: single write.
- pend is set by flush_req_i in any state.
- pend is cleared on the transition into FLUSH.
- A request arriving in WAIT merges with the pending one.
- A request arriving in FLUSH or DONE keeps pend=1, so a second full sweep follows DONE.
- Transitions:
  - IDLE → FLUSH when (flush_req_i|pend) & ~cache_busy_i.
  - IDLE → WAIT when (flush_req_i|pend) & cache_busy_i.
  - IDLE → INVAL when inval_req_i & ~cache_busy_i & ~flush_req_i & ~pend. inv_idx←inval_idx_i.
  - WAIT → FLUSH when ~cache_busy_i.
  - FLUSH: cnt increments each cycle. When cnt==all-ones, go to DONE and cnt wraps to 0.
  - DONE → IDLE unconditionally.
  - INVAL → IDLE unconditionally.
- Entering FLUSH always sets cnt=0.
- Outputs are combinational from registered state only; there is no input-to-output path.
  - flush_ena_o = (state==FLUSH).
  - valid_we_o = (state==FLUSH)|(state==INVAL).
  - valid_addr_o = cnt in FLUSH, inv_idx in INVAL, 0 otherwise.
  - inval_ack_o = (state==INVAL).
  - flush_done_o = (state==DONE).
  - flush_busy_o = pend | (state∈{WAIT,FLUSH,DONE}).
- Flush has precedence: a held inval_req_i waits through any flush and is served only from IDLE.
- Once INVAL is entered it completes; a flush_req_i in that cycle only sets pend.
- cache_busy_i is ignored once FLUSH or INVAL has been entered.

## Timing
- Reset (asynchronous, rstn_i=0): state=IDLE, cnt=0, pend=0, inv_idx=0. All outputs 0.
- Flush with busy low, request sampled at edge k:
  - Sets at k+1 … k+2^IDX carry addresses 0 … 2^IDX−1, with flush_ena_o=valid_we_o=1.
  - flush_done_o is high in cycle k+2^IDX+1.
  - The FSM is in IDLE at k+2^IDX+2.
- Flush with busy high at request: FLUSH begins the cycle after the first edge that samples cache_busy_i=0.
- Invalidation: inval_req_i sampled at edge k (conditions met) → write plus inval_ack_o in cycle k+1.
  - The requester drops inval_req_i after seeing the ack.
  - If inval_req_i is still high in IDLE at the next edge, a new invalidation is started.
- Reset asserted mid-sweep: the sweep is abandoned, with no done pulse and pend cleared. The requester reissues the flush after reset.

## Test plan
- IDX=6; reset, then flush_req_i pulse with cache_busy_i=0 → 64 consecutive writes, addr 0..63, mask 4'b1111, flush_ena_o=1 throughout. flush_done_o single pulse 65 cycles after request; flush_busy_o high from request cycle+1 to done.
- flush_req_i with cache_busy_i=1 for 5 cycles → no writes during WAIT, flush_busy_o=1. First write (addr 0) in the cycle after busy drops.
- inval_req_i=1, inval_idx_i=6'd37, busy 0 → one write, addr 37, inval_ack_o=1 in the next cycle; no further writes after the requester drops inval_req_i.
- inval_req_i and flush_req_i in the same cycle → full 64-set sweep first, done pulse, then single INVAL write to the held index with ack.
- Second flush_req_i pulse at sweep address 20 → after the first done pulse, a second complete 64-cycle sweep and a second done pulse.
- rstn_i low at sweep address 30 → all outputs 0 immediately. After release: IDLE, no done pulse, cnt restarts at 0 on the next request.
